// File: rtl/store_align_pkg.sv
// store_align_pkg: store size encodings and byte-enable patterns shared by the store path
package store_align_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
endpackage

// File: rtl/store_align_if.sv
// store_align_if: store request in, formatted memory write out
interface store_align_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [1:0]            size;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            byte_en;
  logic                  misalign;
  modport master (output in_valid, addr, write_data, size, out_ready,
                  input  in_ready, out_valid, mem_addr, mem_wdata, byte_en, misalign);
  modport slave  (input  in_valid, addr, write_data, size, out_ready,
                  output in_ready, out_valid, mem_addr, mem_wdata, byte_en, misalign);
endinterface

// File: rtl/store_align_fifo.sv
// store_fifo: DEPTH-entry synchronous fifo, storage unreset, pointers wrap modulo DEPTH
module store_fifo #(
  parameter int W     = 68,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end
  assign dout  = mem[rp];
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/store_align.sv
// store_align: formats store data into byte lanes and buffers aligned writes toward data memory
module store_align import store_align_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input logic          clk,
  input logic          rst_n,
  store_align_if.slave bus
);
  localparam int W = ADDR_WIDTH + DATA_WIDTH + 4;
  logic [DATA_WIDTH-1:0] fdata;
  logic [3:0]            fbe;
  logic                  mis, accept, push, pop, full, empty, misalign_q;
  logic [W-1:0]          din, dout;
  always_comb begin
    fdata = bus.size == SZ_BYTE ? {(DATA_WIDTH/8){bus.write_data[7:0]}} :
            bus.size == SZ_HALF ? {(DATA_WIDTH/16){bus.write_data[15:0]}} : bus.write_data;
    fbe   = bus.size == SZ_BYTE ? BE_BYTE << bus.addr[1:0] :
            bus.size == SZ_HALF ? (bus.addr[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
    mis   = bus.size == SZ_ILL || (bus.size == SZ_HALF && bus.addr[0]) ||
            (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00);
  end
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !mis;
  assign pop    = bus.out_valid && bus.out_ready;
  assign din    = {bus.addr[ADDR_WIDTH-1:2], 2'b00, fdata, fbe};
  store_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else misalign_q <= accept && mis;
  end
  assign {bus.mem_addr, bus.mem_wdata, bus.byte_en} = dout;
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_store_align.sv
// tb_store_align: directed checks of store formatting, misalign, buffering and reset
module tb_store_align;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  store_align_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  store_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.size = sz;
    bus.addr = a;
    bus.write_data = d;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.addr = '0;
    bus.write_data = '0;
    bus.size = 2'b00;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_misalign", bus.misalign, 0);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    req(2'b00, 32'h1003, 32'h123456AB);
    tick();
    bus.in_valid = 1'b0;
    chk("sb_valid", bus.out_valid, 1);
    chk("sb_addr", bus.mem_addr, 32'h1000);
    chk("sb_data", bus.mem_wdata, 32'hABABABAB);
    chk("sb_be", bus.byte_en, 4'b1000);
    chk("sb_mis", bus.misalign, 0);
    tick();
    chk("sb_drained", bus.out_valid, 0);
    req(2'b00, 32'h1001, 32'h000000C3);
    tick();
    bus.in_valid = 1'b0;
    chk("sb1_be", bus.byte_en, 4'b0010);
    chk("sb1_data", bus.mem_wdata, 32'hC3C3C3C3);
    tick();
    req(2'b01, 32'h2002, 32'hDEADBEEF);
    tick();
    chk("sh_addr", bus.mem_addr, 32'h2000);
    chk("sh_data", bus.mem_wdata, 32'hBEEFBEEF);
    chk("sh_be", bus.byte_en, 4'b1100);
    req(2'b10, 32'h2004, 32'hCAFEF00D);
    tick();
    bus.in_valid = 1'b0;
    chk("sw_addr", bus.mem_addr, 32'h2004);
    chk("sw_data", bus.mem_wdata, 32'hCAFEF00D);
    chk("sw_be", bus.byte_en, 4'b1111);
    req(2'b01, 32'h2010, 32'h00001234);
    tick();
    bus.in_valid = 1'b0;
    chk("shlo_be", bus.byte_en, 4'b0011);
    chk("shlo_data", bus.mem_wdata, 32'h12341234);
    tick();
    chk("sh_drained", bus.out_valid, 0);
    req(2'b10, 32'h3002, 32'h11111111);
    tick();
    bus.in_valid = 1'b0;
    chk("sw_mis_pulse", bus.misalign, 1);
    chk("sw_mis_noout", bus.out_valid, 0);
    tick();
    chk("sw_mis_clear", bus.misalign, 0);
    chk("sw_mis_noout2", bus.out_valid, 0);
    req(2'b11, 32'h3000, 32'h22222222);
    tick();
    bus.in_valid = 1'b0;
    chk("ill_mis_pulse", bus.misalign, 1);
    chk("ill_noout", bus.out_valid, 0);
    tick();
    chk("ill_mis_clear", bus.misalign, 0);
    req(2'b01, 32'h3001, 32'h33333333);
    tick();
    bus.in_valid = 1'b0;
    chk("sh_mis_pulse", bus.misalign, 1);
    chk("sh_mis_noout", bus.out_valid, 0);
    tick();
    bus.out_ready = 1'b0;
    req(2'b10, 32'h4000, 32'h00000001);
    tick();
    req(2'b10, 32'h4004, 32'h00000002);
    tick();
    req(2'b10, 32'h4008, 32'h00000003);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head", bus.mem_wdata, 32'h1);
    tick();
    chk("full_hold_ready", bus.in_ready, 0);
    chk("full_hold_head", bus.mem_wdata, 32'h1);
    bus.out_ready = 1'b1;
    tick();
    chk("pop1_data", bus.mem_wdata, 32'h2);
    chk("pop1_addr", bus.mem_addr, 32'h4004);
    chk("pop1_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("pop2_data", bus.mem_wdata, 32'h3);
    chk("pop2_addr", bus.mem_addr, 32'h4008);
    chk("pop2_valid", bus.out_valid, 1);
    tick();
    chk("order_drained", bus.out_valid, 0);
    req(2'b10, 32'h5000, 32'h00000100);
    tick();
    chk("stream_head", bus.mem_wdata, 32'h100);
    for (int i = 1; i <= 8; i++) begin
      req(2'b10, 32'h5000 + 32'(4 * i), 32'h100 + 32'(i));
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_ready", bus.in_ready, 1);
      chk("stream_data", bus.mem_wdata, 32'h100 + 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    req(2'b10, 32'h6000, 32'hAAAA0000);
    tick();
    req(2'b10, 32'h6004, 32'hBBBB0000);
    tick();
    bus.in_valid = 1'b0;
    chk("prerst_full", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", bus.out_valid, 0);
    tick();
    chk("postrst_valid2", bus.out_valid, 0);
    chk("postrst_mis", bus.misalign, 0);
    req(2'b00, 32'h7002, 32'h0000005A);
    tick();
    bus.in_valid = 1'b0;
    chk("postrst_new_be", bus.byte_en, 4'b0100);
    chk("postrst_new_data", bus.mem_wdata, 32'h5A5A5A5A);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
